// File: rtl/ifetch_block.sv
// Instruction-fetch stage: fetch PC, 1-cycle synchronous imem interface and IF/ID register.
// A one-entry skid buffer catches the word that lands while decode is stalled.
module ifetch_block #(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [5:0]      HALT_OP  = 6'b111111
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  output logic            imem_en,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     ins,
  output logic            ins_valid,
  output logic [PC_W-1:0] pc_id,
  output logic            halted
);

  typedef enum logic {RUN, HALT} state_t;
  state_t state, state_d;

  logic [PC_W-1:0] pc_f, pend_pc, hold_pc;
  logic            pend_v, hold_v;
  logic [31:0]     hold_ins;

  logic            src_v, src_halt;
  logic [31:0]     src_ins;
  logic [PC_W-1:0] src_pc;

  // The skid entry is always older than anything arriving on imem_rdata.
  always_comb begin
    src_v    = hold_v | pend_v;
    src_ins  = hold_v ? hold_ins : imem_rdata;
    src_pc   = hold_v ? hold_pc  : pend_pc;
    src_halt = src_v && (src_ins[31:26] == HALT_OP);
  end

  always_comb begin
    state_d = state;
    if (br_taken)                state_d = RUN;
    else if (!stall && src_halt) state_d = HALT;
  end

  assign imem_en   = !reset && (state == RUN) && !stall;
  assign imem_addr = pc_f;
  assign halted    = (state == HALT);

  always_ff @(posedge clk) begin
    state <= reset ? RUN : state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_f      <= RESET_PC;
      pend_v    <= 1'b0;
      hold_v    <= 1'b0;
      ins       <= '0;
      ins_valid <= 1'b0;
      pc_id     <= '0;
    end else if (br_taken) begin
      pc_f      <= br_target;
      pend_v    <= 1'b0;
      hold_v    <= 1'b0;
      ins       <= '0;
      ins_valid <= 1'b0;
    end else if (stall) begin
      if (pend_v) begin
        hold_ins <= imem_rdata;
        hold_pc  <= pend_pc;
        hold_v   <= 1'b1;
        pend_v   <= 1'b0;
      end
    end else begin
      hold_v    <= 1'b0;
      ins       <= src_v ? src_ins : 32'h0;
      ins_valid <= src_v;
      if (src_v) pc_id <= src_pc;
      if (src_halt) begin
        // Younger word already requested is dropped; resume point is past the halt.
        pend_v <= 1'b0;
        pc_f   <= src_pc + PC_W'(1);
      end else begin
        pend_v  <= imem_en;
        pend_pc <= pc_f;
        if (imem_en) pc_f <= pc_f + PC_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ifetch_block.sv
// Bench for ifetch_block: directed scenarios plus random stall/branch/reset traffic
// checked against a queue-based model of in-flight fetches.
module tb_ifetch_block;

  logic        clk = 0;
  logic        reset, stall, br_taken;
  logic [15:0] br_target;
  logic        imem_en, halted, ins_valid;
  logic [15:0] imem_addr, pc_id;
  logic [31:0] imem_rdata, ins;
  logic        imem_en2, halted2, ins_valid2;
  logic [15:0] imem_addr2, pc_id2;
  logic [31:0] imem_rdata2, ins2;

  logic [31:0] mem [0:65535];
  int total = 0, bad = 0;

  // model state
  logic [15:0] m_pc, m_pcid;
  logic [31:0] m_ins;
  logic        m_v, m_halt;
  logic [15:0] q[$];

  always #5 clk = ~clk;

  ifetch_block #(.PC_W(16), .RESET_PC(16'h0000), .HALT_OP(6'b111111)) dut (
    .clk(clk), .reset(reset), .stall(stall), .br_taken(br_taken), .br_target(br_target),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .ins(ins), .ins_valid(ins_valid), .pc_id(pc_id), .halted(halted));

  ifetch_block #(.PC_W(16), .RESET_PC(16'hFFFF), .HALT_OP(6'b111111)) dut2 (
    .clk(clk), .reset(reset), .stall(stall), .br_taken(br_taken), .br_target(br_target),
    .imem_en(imem_en2), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
    .ins(ins2), .ins_valid(ins_valid2), .pc_id(pc_id2), .halted(halted2));

  always @(posedge clk) begin
    if (imem_en)  imem_rdata  <= mem[imem_addr];
    if (imem_en2) imem_rdata2 <= mem[imem_addr2];
  end

  // Model: q holds addresses requested but not yet presented on ins.
  task automatic model_step(input logic r, s, b, input logic [15:0] t);
    logic en;
    logic [15:0] p;
    if (r) begin
      m_pc = 16'h0000; q.delete(); m_ins = 0; m_v = 0; m_pcid = 0; m_halt = 0;
    end else if (b) begin
      m_pc = t; q.delete(); m_ins = 0; m_v = 0; m_halt = 0;
    end else if (!s) begin
      en = !m_halt;
      p  = 0;
      if (q.size() > 0) begin
        p = q.pop_front(); m_ins = mem[p]; m_v = 1; m_pcid = p;
      end else begin
        m_ins = 0; m_v = 0;
      end
      if (m_v && m_ins[31:26] == 6'h3F) begin
        m_halt = 1; m_pc = p + 16'd1;
      end else if (en) begin
        q.push_back(m_pc); m_pc = m_pc + 16'd1;
      end
    end
  endtask

  task automatic tick(input logic r, s, b, input logic [15:0] t);
    reset = r; stall = s; br_taken = b; br_target = t;
    @(posedge clk);
    model_step(r, s, b, t);
    @(negedge clk);
  endtask

  task automatic test_reset;
    tick(1, 0, 0, 0); tick(1, 0, 0, 0);
    total++; if (ins !== 32'h0 || ins_valid !== 1'b0) begin bad++; $display("FAIL reset_ins: got %h/%b want 0/0", ins, ins_valid); end
    total++; if (pc_id !== 16'h0 || halted !== 1'b0) begin bad++; $display("FAIL reset_pcid: got %h/%b want 0/0", pc_id, halted); end
    total++; if (imem_en !== 1'b0) begin bad++; $display("FAIL reset_en: got %b want 0", imem_en); end
  endtask

  task automatic test_stream;
    tick(0, 0, 0, 0);
    total++; if (ins_valid !== 1'b0 || imem_en !== 1'b1 || imem_addr !== 16'h1) begin
      bad++; $display("FAIL stream_first: got v=%b en=%b addr=%h want 0 1 0001", ins_valid, imem_en, imem_addr); end
    for (int k = 0; k < 3; k++) begin
      tick(0, 0, 0, 0);
      total++; if (ins !== 32'h100 + k || ins_valid !== 1'b1 || pc_id !== 16'(k)) begin
        bad++; $display("FAIL stream_%0d: got %h/%b pc %h want %h/1 pc %h", k, ins, ins_valid, pc_id, 32'h100 + k, k); end
    end
  endtask

  task automatic test_stall;
    tick(0, 0, 0, 0); tick(0, 0, 0, 0);
    total++; if (pc_id !== 16'h4 || ins !== 32'h104) begin bad++; $display("FAIL stall_pre: got pc %h ins %h want 0004 104", pc_id, ins); end
    for (int k = 0; k < 3; k++) begin
      tick(0, 1, 0, 0);
      total++; if (ins !== 32'h104 || pc_id !== 16'h4 || ins_valid !== 1'b1 || imem_en !== 1'b0) begin
        bad++; $display("FAIL stall_hold_%0d: got %h pc %h v %b en %b want 104 0004 1 0", k, ins, pc_id, ins_valid, imem_en); end
    end
    for (int k = 5; k < 7; k++) begin
      tick(0, 0, 0, 0);
      total++; if (ins !== 32'h100 + k || pc_id !== 16'(k) || ins_valid !== 1'b1) begin
        bad++; $display("FAIL stall_after_%0d: got %h pc %h want %h pc %h", k, ins, pc_id, 32'h100 + k, k); end
    end
  endtask

  task automatic test_branch;
    tick(0, 0, 0, 0);
    tick(0, 0, 1, 16'h20);
    total++; if (ins_valid !== 1'b0 || ins !== 32'h0 || imem_addr !== 16'h20) begin
      bad++; $display("FAIL br_kill: got v %b ins %h addr %h want 0 0 0020", ins_valid, ins, imem_addr); end
    tick(0, 0, 0, 0);
    total++; if (ins_valid !== 1'b0) begin bad++; $display("FAIL br_bubble: got v %b want 0", ins_valid); end
    tick(0, 0, 0, 0);
    total++; if (ins !== 32'h120 || pc_id !== 16'h20 || ins_valid !== 1'b1) begin
      bad++; $display("FAIL br_target: got %h pc %h v %b want 120 0020 1", ins, pc_id, ins_valid); end
  endtask

  task automatic test_branch_stall;
    tick(0, 0, 0, 0);
    tick(0, 1, 0, 0);
    tick(0, 1, 1, 16'h30);
    total++; if (ins_valid !== 1'b0) begin bad++; $display("FAIL brst_kill: got v %b want 0", ins_valid); end
    tick(0, 0, 0, 0);
    total++; if (ins_valid !== 1'b0) begin bad++; $display("FAIL brst_skid: got v %b ins %h want 0", ins_valid, ins); end
    tick(0, 0, 0, 0);
    total++; if (ins !== 32'h130 || pc_id !== 16'h30 || ins_valid !== 1'b1) begin
      bad++; $display("FAIL brst_target: got %h pc %h want 130 0030", ins, pc_id); end
  endtask

  task automatic test_halt;
    tick(1, 0, 0, 0);
    mem[5] = 32'hFC000000;
    for (int k = 0; k < 6; k++) tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    total++; if (pc_id !== 16'h5 || ins !== 32'hFC000000 || ins_valid !== 1'b1 || halted !== 1'b1) begin
      bad++; $display("FAIL halt_word: got pc %h ins %h v %b h %b want 0005 fc000000 1 1", pc_id, ins, ins_valid, halted); end
    total++; if (imem_en !== 1'b0 || imem_addr !== 16'h6) begin
      bad++; $display("FAIL halt_fetch: got en %b addr %h want 0 0006", imem_en, imem_addr); end
    tick(0, 0, 0, 0);
    total++; if (ins_valid !== 1'b0 || ins !== 32'h0 || halted !== 1'b1) begin
      bad++; $display("FAIL halt_after: got v %b ins %h h %b want 0 0 1", ins_valid, ins, halted); end
    tick(0, 0, 0, 0); tick(0, 0, 0, 0);
    total++; if (imem_en !== 1'b0 || ins_valid !== 1'b0) begin bad++; $display("FAIL halt_stay: got en %b v %b want 0 0", imem_en, ins_valid); end
    tick(0, 0, 1, 16'h0);
    total++; if (halted !== 1'b0 || imem_en !== 1'b1) begin bad++; $display("FAIL halt_resume: got h %b en %b want 0 1", halted, imem_en); end
    tick(0, 0, 0, 0); tick(0, 0, 0, 0);
    total++; if (pc_id !== 16'h0 || ins !== 32'h100 || ins_valid !== 1'b1) begin
      bad++; $display("FAIL halt_restart: got pc %h ins %h want 0000 100", pc_id, ins); end
    tick(1, 0, 0, 0);
    mem[5] = 32'h105;
  endtask

  task automatic test_wrap;
    tick(1, 0, 0, 0);
    tick(0, 0, 0, 0); tick(0, 0, 0, 0);
    total++; if (pc_id2 !== 16'hFFFF || ins2 !== 32'h100FF || ins_valid2 !== 1'b1) begin
      bad++; $display("FAIL wrap_top: got pc %h ins %h want ffff 100ff", pc_id2, ins2); end
    tick(0, 0, 0, 0);
    total++; if (pc_id2 !== 16'h0 || ins2 !== 32'h100 || ins_valid2 !== 1'b1) begin
      bad++; $display("FAIL wrap_zero: got pc %h ins %h want 0000 100", pc_id2, ins2); end
    tick(0, 1, 0, 0); tick(0, 1, 0, 0);
    tick(1, 1, 0, 0);
    total++; if (ins !== 32'h0 || ins_valid !== 1'b0 || pc_id !== 16'h0 || halted !== 1'b0 || imem_en !== 1'b0) begin
      bad++; $display("FAIL rst_mid_stall: got ins %h v %b pc %h h %b en %b want all 0", ins, ins_valid, pc_id, halted, imem_en); end
    total++; if (ins2 !== 32'h0 || ins_valid2 !== 1'b0 || pc_id2 !== 16'h0 || imem_addr2 !== 16'hFFFF) begin
      bad++; $display("FAIL rst_mid_stall2: got ins %h v %b pc %h addr %h want 0 0 0000 ffff", ins2, ins_valid2, pc_id2, imem_addr2); end
  endtask

  task automatic test_random;
    logic r, s, b, exp_en;
    tick(1, 0, 0, 0);
    mem[37] = 32'hFC001234; mem[50] = 32'hFFFFFFFF;
    for (int k = 0; k < 400; k++) begin
      r = ($urandom % 100) < 2;
      s = ($urandom % 100) < 30;
      b = ($urandom % 100) < 6;
      tick(r, s, b, 16'($urandom % 64));
      exp_en = !reset && !m_halt && !stall;
      total++;
      if (ins !== m_ins || ins_valid !== m_v || (m_v && pc_id !== m_pcid) || halted !== m_halt ||
          imem_en !== exp_en || imem_addr !== m_pc) begin
        bad++;
        $display("FAIL rand_%0d: got ins %h v %b pc %h h %b en %b addr %h want %h %b %h %b %b %h",
                 k, ins, ins_valid, pc_id, halted, imem_en, imem_addr, m_ins, m_v, m_pcid, m_halt, exp_en, m_pc);
      end
    end
    tick(1, 0, 0, 0);
    mem[37] = 32'h125; mem[50] = 32'h132;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = i + 32'h100;
    reset = 1; stall = 0; br_taken = 0; br_target = 0;
    m_pc = 0; m_pcid = 0; m_ins = 0; m_v = 0; m_halt = 0;
    @(negedge clk);
    test_reset;
    test_stream;
    test_stall;
    test_branch;
    test_branch_stall;
    test_halt;
    test_wrap;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
